// File: rtl/line_draw_scheduler.sv
// Round-robin scheduler that shares one line drawer among N requesters.
// Each job is loaded, run and completed or aborted, and turned into a pixel-write stream.
module line_draw_scheduler #(
  parameter int N       = 2,
  parameter int SETUP   = 2,
  parameter int TIMEOUT = 2000000,
  parameter int OW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic signed [N*11-1:0] req_x0,
  input  logic signed [N*11-1:0] req_y0,
  input  logic signed [N*11-1:0] req_x1,
  input  logic signed [N*11-1:0] req_y1,
  input  logic [N-1:0]           req_color,
  output logic [N-1:0]           grant,
  output logic                   ld_start,
  output logic signed [10:0]     ld_x0,
  output logic signed [10:0]     ld_y0,
  output logic signed [10:0]     ld_x1,
  output logic signed [10:0]     ld_y1,
  input  logic signed [10:0]     ld_x,
  input  logic signed [10:0]     ld_y,
  input  logic                   ld_done,
  output logic                   pix_we,
  output logic signed [10:0]     pix_x,
  output logic signed [10:0]     pix_y,
  output logic                   pix_color,
  output logic                   busy,
  output logic [OW-1:0]          owner,
  output logic                   line_done,
  output logic                   abort
);

  localparam int SW = $clog2(SETUP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t              state, state_next;
  logic [OW-1:0]       ptr;
  logic [SW-1:0]       setup_cnt;
  logic [TW-1:0]       timer;
  logic                color;
  logic                abort_flag;
  logic                last_valid;
  logic signed [10:0]  last_x, last_y;

  logic                found;
  logic [OW-1:0]       sel;
  logic [N-1:0]        grant_next;
  logic                ld_start_next, line_done_next, abort_next, busy_next;
  logic                emit, go_abort;

  // Round-robin search starting just after the last owner.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = '0;
    ld_start_next  = ld_start;
    line_done_next = 1'b0;
    abort_next     = 1'b0;
    emit           = 1'b0;
    go_abort       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_next[sel] = 1'b1;
          state_next      = LOAD;
        end
      end
      LOAD: begin
        if (setup_cnt == SW'(SETUP - 1)) begin
          ld_start_next = 1'b1;
          state_next    = RUN;
        end
      end
      RUN: begin
        // One write per distinct drawer position; the endpoint is caught in the done cycle too.
        emit = !last_valid || (ld_x != last_x) || (ld_y != last_y);
        if (ld_done) begin
          state_next = FIN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_next = FIN;
          go_abort   = 1'b1;
        end
      end
      FIN: begin
        ld_start_next  = 1'b0;
        line_done_next = !abort_flag;
        abort_next     = abort_flag;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE) || line_done_next || abort_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= OW'(N - 1);
      setup_cnt  <= '0;
      timer      <= '0;
      color      <= 1'b0;
      abort_flag <= 1'b0;
      last_valid <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
      grant      <= '0;
      ld_start   <= 1'b0;
      ld_x0      <= '0;
      ld_y0      <= '0;
      ld_x1      <= '0;
      ld_y1      <= '0;
      pix_we     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= 1'b0;
      busy       <= 1'b0;
      owner      <= '0;
      line_done  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      ld_start  <= ld_start_next;
      line_done <= line_done_next;
      abort     <= abort_next;
      busy      <= busy_next;
      pix_we    <= emit;
      if (emit) begin
        pix_x      <= ld_x;
        pix_y      <= ld_y;
        pix_color  <= color;
        last_x     <= ld_x;
        last_y     <= ld_y;
        last_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            ld_x0      <= req_x0[int'(sel)*11 +: 11];
            ld_y0      <= req_y0[int'(sel)*11 +: 11];
            ld_x1      <= req_x1[int'(sel)*11 +: 11];
            ld_y1      <= req_y1[int'(sel)*11 +: 11];
            color      <= req_color[sel];
            owner      <= sel;
            ptr        <= sel;
            setup_cnt  <= '0;
            abort_flag <= 1'b0;
          end
        end
        LOAD: begin
          setup_cnt <= setup_cnt + SW'(1);
          if (state_next == RUN) begin
            last_valid <= 1'b0;
            timer      <= '0;
          end
        end
        RUN: begin
          timer <= timer + TW'(1);
          if (go_abort) abort_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Scoreboard bench for line_draw_scheduler with a scripted drawer model.
// Expected grants, pixels and completions are queued before each job and popped as the DUT produces them.
module tb_line_draw_scheduler;
  localparam int N       = 2;
  localparam int SETUP   = 2;
  localparam int TIMEOUT = 50;
  localparam int OW      = 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0]           req = '0;
  logic signed [N*11-1:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic [N-1:0]           req_color = '0;
  logic [N-1:0]           grant;
  logic                   ld_start;
  logic signed [10:0]     ld_x0, ld_y0, ld_x1, ld_y1;
  logic signed [10:0]     ld_x = '0, ld_y = '0;
  logic                   ld_done = 1'b0;
  logic                   pix_we;
  logic signed [10:0]     pix_x, pix_y;
  logic                   pix_color;
  logic                   busy;
  logic [OW-1:0]          owner;
  logic                   line_done, abort;

  line_draw_scheduler #(.N(N), .SETUP(SETUP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_color(req_color), .grant(grant), .ld_start(ld_start),
    .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_x(ld_x), .ld_y(ld_y), .ld_done(ld_done),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .busy(busy), .owner(owner), .line_done(line_done), .abort(abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drawer model: mode 0 follows a timed point script, mode 1 walks x0->x1 one step per cycle.
  int mode = 0;
  int pt_x[$], pt_y[$], pt_t[$];
  int done_t = -1;
  int pcyc = 0;

  function automatic int pos_x(input int c);
    int r;
    if (mode == 1) begin
      r = int'(ld_x0) + c;
      if (r > int'(ld_x1)) r = int'(ld_x1);
    end else begin
      r = (pt_x.size() > 0) ? pt_x[0] : 0;
      for (int k = 0; k < pt_x.size(); k++) if (pt_t[k] <= c) r = pt_x[k];
    end
    return r;
  endfunction

  function automatic int pos_y(input int c);
    int r;
    if (mode == 1) r = int'(ld_y0);
    else begin
      r = (pt_y.size() > 0) ? pt_y[0] : 0;
      for (int k = 0; k < pt_y.size(); k++) if (pt_t[k] <= c) r = pt_y[k];
    end
    return r;
  endfunction

  function automatic logic pos_done(input int c);
    if (mode == 1) return (int'(ld_x0) + c) >= int'(ld_x1);
    return (done_t >= 0) && (c >= done_t);
  endfunction

  always @(posedge clk) begin
    pcyc    <= ld_start ? pcyc + 1 : 0;
    ld_x    <= 11'(pos_x(ld_start ? pcyc + 1 : 0));
    ld_y    <= 11'(pos_y(ld_start ? pcyc + 1 : 0));
    ld_done <= pos_done(ld_start ? pcyc + 1 : 0);
  end

  // Scoreboard
  int          exp_grant[$];
  logic [22:0] exp_pix[$];
  int          exp_end[$];    // 0 = line_done, 1 = abort
  int          ends_seen = 0;
  bit          job_open = 0;

  function automatic logic [22:0] pk(input int x, input int y, input int c);
    return {11'(x), 11'(y), 1'(c)};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      job_open = 0;
    end else begin
      if (grant != '0) begin
        $display("grant %b owner %0d", grant, owner);
        if (job_open) check("grant_overlap", 32'(1), 32'(0));
        job_open = 1;
        if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant), 32'(0));
        else begin
          int g;
          g = exp_grant.pop_front();
          check("grant", 32'(grant), 32'(1) << g);
          check("owner", 32'(owner), 32'(g));
        end
      end
      if (pix_we) begin
        $display("pix (%0d,%0d) color %0d", pix_x, pix_y, pix_color);
        if (exp_pix.size() == 0) check("pix_unexpected", 32'({pix_x, pix_y, pix_color}), 32'(0));
        else check("pix", 32'({pix_x, pix_y, pix_color}), 32'(exp_pix.pop_front()));
      end
      if (line_done || abort) begin
        $display("end line_done %0d abort %0d", line_done, abort);
        job_open = 0;
        ends_seen++;
        if (exp_end.size() == 0) check("end_unexpected", 32'({line_done, abort}), 32'(0));
        else check("end_kind", 32'({line_done, abort}), (exp_end.pop_front() == 0) ? 32'(2) : 32'(1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int i, input int x0, input int y0, input int x1, input int y1, input int c);
    req_x0[i*11 +: 11] = 11'(x0);
    req_y0[i*11 +: 11] = 11'(y0);
    req_x1[i*11 +: 11] = 11'(x1);
    req_y1[i*11 +: 11] = 11'(y1);
    req_color[i]       = 1'(c);
  endtask

  task automatic set_script(input int x0, input int y0, input int x1, input int y1, input int t1, input int dt);
    mode = 0;
    pt_x = {x0, x1}; pt_y = {y0, y1}; pt_t = {0, t1};
    done_t = dt;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == '0 && n < 30) begin tick(); n++; end
    check(tag, 32'(grant != '0), 32'(1));
  endtask

  task automatic wait_ends(input string tag, input int target);
    int n;
    n = 0;
    while (ends_seen < target && n < 400) begin tick(); n++; end
    check(tag, 32'(ends_seen), 32'(target));
  endtask

  task automatic drain(input string tag);
    check({tag, "_grants_left"}, 32'(exp_grant.size()), 32'(0));
    check({tag, "_pix_left"}, 32'(exp_pix.size()), 32'(0));
    check({tag, "_ends_left"}, 32'(exp_end.size()), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int n, g, base;

    // Reset state
    tick();
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy", 32'({busy, ld_start, pix_we, line_done, abort}), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    check("rst_ld_x0", 32'({ld_x0, pix_x}), 32'(0));
    reset = 1'b0;
    tick();

    // Single job, drawer advancing every second cycle
    mode = 0;
    pt_x = {20, 21, 22, 23, 24, 25};
    pt_y = {20, 20, 21, 21, 22, 22};
    pt_t = {0, 2, 4, 6, 8, 10};
    done_t = 11;
    set_job(0, 20, 20, 25, 22, 1);
    exp_grant.push_back(0);
    for (int k = 0; k < 6; k++) exp_pix.push_back(pk(pt_x[k], pt_y[k], 1));
    exp_end.push_back(0);
    base = ends_seen;
    req = 2'b01;
    wait_grant("single_grant_wait");
    req = '0;
    check("single_ld_x0", 32'(ld_x0), 32'(20));
    check("single_ld_y1", 32'(ld_y1), 32'(22));
    n = 0;
    while (!ld_start && n < 20) begin n++; tick(); end
    check("setup_len", 32'(n), 32'(SETUP));
    check("run_busy", 32'(busy), 32'(1));
    wait_ends("single_end", base + 1);
    tick();
    check("busy_after_end", 32'(busy), 32'(0));
    drain("single");

    // Contention: both requesters held for four jobs
    do_reset();
    mode = 1;
    set_job(0, 0, 5, 2, 5, 0);
    set_job(1, 10, 7, 11, 7, 1);
    for (int j = 0; j < 2; j++) begin
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      for (int x = 0; x <= 2; x++) exp_pix.push_back(pk(x, 5, 0));
      for (int x = 10; x <= 11; x++) exp_pix.push_back(pk(x, 7, 1));
      exp_end.push_back(0);
      exp_end.push_back(0);
    end
    base = ends_seen;
    g = 0;
    n = 0;
    req = 2'b11;
    while (g < 4 && n < 300) begin
      tick();
      n++;
      if (grant != '0) g++;
    end
    req = '0;
    check("contention_grants", 32'(g), 32'(4));
    wait_ends("contention_end", base + 4);
    drain("contention");

    // Stalled drawer position, then one step
    do_reset();
    set_script(30, 30, 31, 30, 40, 41);
    set_job(0, 30, 30, 31, 30, 1);
    exp_grant.push_back(0);
    exp_pix.push_back(pk(30, 30, 1));
    exp_pix.push_back(pk(31, 30, 1));
    exp_end.push_back(0);
    base = ends_seen;
    req = 2'b01;
    wait_grant("stall_grant_wait");
    req = '0;
    wait_ends("stall_end", base + 1);
    drain("stall");

    // Zero-length line
    set_script(100, 100, 100, 100, 0, 1);
    set_job(0, 100, 100, 100, 100, 1);
    exp_grant.push_back(0);
    exp_pix.push_back(pk(100, 100, 1));
    exp_end.push_back(0);
    base = ends_seen;
    req = 2'b01;
    wait_grant("zero_grant_wait");
    req = '0;
    wait_ends("zero_end", base + 1);
    drain("zero");

    // Timeout: drawer never finishes
    set_script(7, 8, 7, 8, 0, -1);
    set_job(0, 7, 8, 9, 8, 1);
    exp_grant.push_back(0);
    exp_pix.push_back(pk(7, 8, 1));
    exp_end.push_back(1);
    base = ends_seen;
    req = 2'b01;
    wait_grant("timeout_grant_wait");
    req = '0;
    n = 0;
    while (!ld_start && n < 20) begin n++; tick(); end
    n = 0;
    while (!abort && n < TIMEOUT + 10) begin tick(); n++; end
    check("timeout_latency_ok", 32'(n >= TIMEOUT && n <= TIMEOUT + 1), 32'(1));
    check("timeout_ld_start", 32'(ld_start), 32'(0));
    tick();
    check("timeout_end_count", 32'(ends_seen), 32'(base + 1));
    set_script(50, 60, 50, 60, 0, 1);
    set_job(1, 50, 60, 50, 60, 0);
    exp_grant.push_back(1);
    exp_pix.push_back(pk(50, 60, 0));
    exp_end.push_back(0);
    base = ends_seen;
    req = 2'b10;
    wait_grant("after_timeout_grant_wait");
    req = '0;
    wait_ends("after_timeout_end", base + 1);
    drain("timeout");

    // Asynchronous reset in the middle of a run
    set_script(40, 40, 41, 40, 100, -1);
    set_job(0, 40, 40, 45, 40, 1);
    exp_grant.push_back(0);
    exp_pix.push_back(pk(40, 40, 1));
    req = 2'b01;
    wait_grant("midreset_grant_wait");
    req = '0;
    n = 0;
    while (!ld_start && n < 20) begin n++; tick(); end
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("midreset_outs", 32'({busy, ld_start, pix_we}), 32'(0));
    drain("midreset");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    set_script(9, 9, 9, 9, 0, 1);
    set_job(1, 9, 9, 9, 9, 1);
    exp_grant.push_back(1);
    exp_pix.push_back(pk(9, 9, 1));
    exp_end.push_back(0);
    base = ends_seen;
    req = 2'b10;
    wait_grant("post_reset_grant_wait");
    req = '0;
    wait_ends("post_reset_end", base + 1);
    repeat (3) tick();
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
